// File: rtl/cpu_wrapper_v3.sv
// rtl/cpu_wrapper_v3.sv - 8-bit five-stage pipelined CPU top with unified 256-byte memory
// Interrupt, EPC and RTI support is built only when CPU_INT_EN is defined.

module cpu_mem (
  input  logic       clk,
  input  logic [7:0] iaddr,
  output logic [7:0] ins0,
  output logic [7:0] ins1,
  input  logic [7:0] daddr,
  output logic [7:0] rdata,
  input  logic       we,
  input  logic [7:0] wdata
);
  logic [7:0] mem [0:255];
  logic [7:0] iaddr_next;

  assign iaddr_next = iaddr + 8'd1;
  assign ins0       = mem[iaddr];
  assign ins1       = mem[iaddr_next];
  assign rdata      = mem[daddr];

  always_ff @(posedge clk) begin
    if (we) mem[daddr] <= wdata;
  end
endmodule

module cpu_regfile (
  input  logic       clk,
  input  logic       rstn,
  input  logic       we,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [1:0] addr_a,
  input  logic [1:0] addr_b,
  output logic [7:0] data_a,
  output logic [7:0] data_b
);
  logic [7:0] regs [0:3];

  // Write-through lets ID see the value WB is committing this cycle.
  assign data_a = (we && wr_addr == addr_a) ? wr_data : regs[addr_a];
  assign data_b = (we && wr_addr == addr_b) ? wr_data : regs[addr_b];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
    end else if (we) begin
      regs[wr_addr] <= wr_data;
    end
  end
endmodule

module cpu_pc (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] pc_next,
  output logic [7:0] pc_current
);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pc_current <= 8'h00;
    else       pc_current <= pc_next;
  end
endmodule

module cpu_wrapper_v3 (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] I_Port,
  input  logic       int_sig,
  output logic [7:0] O_Port
);
  localparam logic [7:0] NOP     = 8'h00;
  localparam logic [7:0] INT_VEC = 8'hF8;

  logic [7:0] pc_current, pc_next, fetch_ins, fetch_imm;
  logic [7:0] ifid_ins, ifid_imm;
  logic [7:0] idex_ins, idex_imm, idex_va, idex_vb;
  logic       idex_we;
  logic [1:0] idex_dst;
  logic       exmem_we, exmem_ld, exmem_mwe, exmem_out;
  logic [1:0] exmem_dst;
  logic [7:0] exmem_res, exmem_addr;
  logic       memwb_we, memwb_out;
  logic [1:0] memwb_dst;
  logic [7:0] memwb_data;
  logic [7:0] mem_rdata, rd_a, rd_b;
  logic       flag_z, flag_c, z_next, c_next;
  logic [2:0] id_use;
  logic [1:0] id_dst;
  logic       hz_a, hz_b, stall, flush, int_req, take_int;
  logic [7:0] ex_res, target;
  logic [8:0] sum;
  logic       ex_ld, ex_mwe, ex_out;

  // {reads R[ra], reads R[rb], writes a register}
  function automatic logic [2:0] decode_use(input logic [7:0] ins);
    logic [1:0] ra;
    ra = ins[3:2];
    case (ins[7:4])
      4'd1:                   decode_use = 3'b011;
      4'd2, 4'd3, 4'd4, 4'd5: decode_use = 3'b111;
      4'd6:  decode_use = (ra == 2'd0) ? 3'b010 : (ra == 2'd1) ? 3'b001 : 3'b000;
      4'd7:  decode_use = (ra != 2'd3) ? 3'b011 : 3'b000;
      4'd8:  decode_use = (ra != 2'd3) ? 3'b010 : 3'b000;
      4'd12: decode_use = (ra == 2'd2) ? 3'b010 : (ra != 2'd3) ? 3'b001 : 3'b000;
      default: decode_use = 3'b000;
    endcase
  endfunction

  cpu_pc PC (.clk(clk), .rstn(rstn), .pc_next(pc_next), .pc_current(pc_current));

  cpu_mem mem_inst (
    .clk(clk), .iaddr(pc_current), .ins0(fetch_ins), .ins1(fetch_imm),
    .daddr(exmem_addr), .rdata(mem_rdata), .we(exmem_mwe), .wdata(exmem_res)
  );

  cpu_regfile regfile_inst (
    .clk(clk), .rstn(rstn), .we(memwb_we), .wr_addr(memwb_dst), .wr_data(memwb_data),
    .addr_a(ifid_ins[3:2]), .addr_b(ifid_ins[1:0]), .data_a(rd_a), .data_b(rd_b)
  );

  assign id_use = decode_use(ifid_ins);
  assign id_dst = (ifid_ins[7:4] >= 4'd1 && ifid_ins[7:4] <= 4'd5) ? ifid_ins[3:2] : ifid_ins[1:0];
  assign hz_a   = (idex_we && idex_dst == ifid_ins[3:2]) || (exmem_we && exmem_dst == ifid_ins[3:2]);
  assign hz_b   = (idex_we && idex_dst == ifid_ins[1:0]) || (exmem_we && exmem_dst == ifid_ins[1:0]);
  assign stall  = (id_use[2] && hz_a) || (id_use[1] && hz_b);

`ifdef CPU_INT_EN
  logic [7:0] epc;
  logic       int_en, ex_rti;
  // Defer while a jump/RTI sits in ID, else its flush would discard the handler fetch.
  assign int_req = int_sig && int_en && ifid_ins[7:4] != 4'd8 && ifid_ins[7:4] != 4'd9;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      epc    <= 8'h00;
      int_en <= 1'b1;
    end else if (flush && ex_rti) begin
      int_en <= 1'b1;
    end else if (take_int) begin
      epc    <= pc_current;
      int_en <= 1'b0;
    end
  end
`else
  logic unused_int;
  assign unused_int = int_sig;
  assign int_req    = 1'b0;
`endif

  assign take_int = int_req && !flush && !stall;

  always_comb begin
    ex_res = idex_vb;
    z_next = flag_z;
    c_next = flag_c;
    flush  = 1'b0;
    target = idex_vb;
    ex_ld  = 1'b0;
    ex_mwe = 1'b0;
    ex_out = 1'b0;
    sum    = 9'd0;
`ifdef CPU_INT_EN
    ex_rti = 1'b0;
`endif
    case (idex_ins[7:4])
      4'd2: begin
        sum = {1'b0, idex_va} + {1'b0, idex_vb};
        ex_res = sum[7:0]; c_next = sum[8]; z_next = (ex_res == 8'd0);
      end
      4'd3: begin
        ex_res = idex_va - idex_vb; c_next = idex_va < idex_vb; z_next = (ex_res == 8'd0);
      end
      4'd4: begin ex_res = idex_va & idex_vb; z_next = (ex_res == 8'd0); end
      4'd5: begin ex_res = idex_va | idex_vb; z_next = (ex_res == 8'd0); end
      4'd6: begin
        if (idex_ins[3:2] == 2'd0)      ex_out = 1'b1;
        else if (idex_ins[3:2] == 2'd1) ex_res = I_Port;
      end
      4'd7: begin
        case (idex_ins[3:2])
          2'd0: begin ex_res = ~idex_vb; z_next = (ex_res == 8'd0); end
          2'd1: begin
            sum = {1'b0, idex_vb} + 9'd1;
            ex_res = sum[7:0]; c_next = sum[8]; z_next = (ex_res == 8'd0);
          end
          2'd2: begin
            ex_res = idex_vb - 8'd1; c_next = (idex_vb == 8'd0); z_next = (ex_res == 8'd0);
          end
          default: ;
        endcase
      end
      4'd8: begin
        case (idex_ins[3:2])
          2'd0:    flush = flag_z;
          2'd1:    flush = flag_c;
          2'd2:    flush = 1'b1;
          default: ;
        endcase
      end
`ifdef CPU_INT_EN
      4'd9: begin flush = 1'b1; target = epc; ex_rti = 1'b1; end
`endif
      4'd12: begin
        case (idex_ins[3:2])
          2'd0:    ex_res = idex_imm;
          2'd1:    ex_ld  = 1'b1;
          2'd2:    ex_mwe = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_next = pc_current + ((fetch_ins[7:4] == 4'd12) ? 8'd2 : 8'd1);
    if (flush)         pc_next = target;
    else if (stall)    pc_next = pc_current;
    else if (take_int) pc_next = INT_VEC;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ifid_ins <= NOP;  ifid_imm <= 8'h00;
      idex_ins <= NOP;  idex_imm <= 8'h00; idex_va <= 8'h00; idex_vb <= 8'h00;
      idex_we  <= 1'b0; idex_dst <= 2'd0;
      exmem_we <= 1'b0; exmem_dst <= 2'd0; exmem_res <= 8'h00; exmem_addr <= 8'h00;
      exmem_ld <= 1'b0; exmem_mwe <= 1'b0; exmem_out <= 1'b0;
      memwb_we <= 1'b0; memwb_dst <= 2'd0; memwb_data <= 8'h00; memwb_out <= 1'b0;
      flag_z   <= 1'b0; flag_c <= 1'b0;    O_Port <= 8'h00;
    end else begin
      flag_z     <= z_next;
      flag_c     <= c_next;
      exmem_we   <= idex_we;
      exmem_dst  <= idex_dst;
      exmem_res  <= ex_res;
      exmem_addr <= idex_imm;
      exmem_ld   <= ex_ld;
      exmem_mwe  <= ex_mwe;
      exmem_out  <= ex_out;
      memwb_we   <= exmem_we;
      memwb_dst  <= exmem_dst;
      memwb_data <= exmem_ld ? mem_rdata : exmem_res;
      memwb_out  <= exmem_out;
      if (memwb_out) O_Port <= memwb_data;
      if (flush) begin
        ifid_ins <= NOP;
        idex_ins <= NOP;
        idex_we  <= 1'b0;
      end else if (stall) begin
        idex_ins <= NOP;
        idex_we  <= 1'b0;
      end else begin
        idex_ins <= ifid_ins;
        idex_imm <= ifid_imm;
        idex_va  <= rd_a;
        idex_vb  <= rd_b;
        idex_we  <= id_use[0];
        idex_dst <= id_dst;
        ifid_ins <= take_int ? NOP : fetch_ins;
        ifid_imm <= fetch_imm;
      end
    end
  end
endmodule

// File: tb/tb_cpu_wrapper_v3.sv
// tb/tb_cpu_wrapper_v3.sv - directed and random-program bench for cpu_wrapper_v3
// Random programs are checked against an instruction-at-a-time ISA interpreter.

module tb_cpu_wrapper_v3;
  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] I_Port;
  logic       int_sig;
  logic [7:0] O_Port;

  int ncomp = 0;
  int nfail = 0;

  logic [7:0] prog [$];
  logic [7:0] m_mem [256];
  logic [7:0] m_regs [4];
  logic       m_z, m_c;
  logic [7:0] m_out;

  cpu_wrapper_v3 dut (
    .clk(clk), .rstn(rstn), .I_Port(I_Port), .int_sig(int_sig), .O_Port(O_Port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic enter_reset();
    rstn    = 1'b0;
    int_sig = 1'b0;
    for (int i = 0; i < 256; i++) dut.mem_inst.mem[i] = 8'h00;
    tick(1);
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog.size(); i++) dut.mem_inst.mem[i[7:0]] = prog[i];
  endtask

  task automatic watch(input int n, input logic [7:0] addr, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (dut.PC.pc_current == addr) seen = 1'b1;
    end
  endtask

  task automatic gen_random(input int k);
    logic [1:0] ra, rb;
    int sel;
    prog = {};
    for (int i = 0; i < k; i++) begin
      ra  = 2'($urandom);
      rb  = 2'($urandom);
      sel = $urandom_range(0, 11);
      case (sel)
        0:          prog.push_back({4'd1, ra, rb});
        1, 2, 3, 4: prog.push_back({sel[3:0] + 4'd1, ra, rb});
        5:          prog.push_back({4'd6, 2'd0, rb});
        6:          prog.push_back({4'd6, 2'd1, rb});
        7:          prog.push_back({4'd7, 2'($urandom_range(0, 2)), rb});
        8:  begin prog.push_back({4'd12, 2'd0, rb}); prog.push_back(8'($urandom)); end
        9:  begin prog.push_back({4'd12, 2'd1, rb}); prog.push_back(8'hE0 + 8'($urandom_range(0, 15))); end
        10: begin prog.push_back({4'd12, 2'd2, rb}); prog.push_back(8'hE0 + 8'($urandom_range(0, 15))); end
        default:    prog.push_back({4'hA, ra, rb});
      endcase
    end
  endtask

  task automatic model_run(input int nbytes);
    int pc;
    logic [7:0] ins, imm, a, b, r;
    logic [1:0] ra, rb;
    logic [8:0] s;
    pc = 0;
    while (pc < nbytes) begin
      ins = m_mem[pc];
      imm = m_mem[(pc + 1) % 256];
      ra  = ins[3:2];
      rb  = ins[1:0];
      a   = m_regs[ra];
      b   = m_regs[rb];
      pc  = pc + ((ins[7:4] == 4'd12) ? 2 : 1);
      case (ins[7:4])
        4'd1: m_regs[ra] = b;
        4'd2: begin s = {1'b0, a} + {1'b0, b}; m_regs[ra] = s[7:0]; m_c = s[8]; m_z = (s[7:0] == 0); end
        4'd3: begin m_regs[ra] = a - b; m_c = (a < b); m_z = (a == b); end
        4'd4: begin r = a & b; m_regs[ra] = r; m_z = (r == 0); end
        4'd5: begin r = a | b; m_regs[ra] = r; m_z = (r == 0); end
        4'd6: if (ra == 0) m_out = b; else if (ra == 1) m_regs[rb] = I_Port;
        4'd7: begin
          if (ra == 0) begin r = ~b; m_regs[rb] = r; m_z = (r == 0); end
          else if (ra == 1) begin r = b + 1; m_regs[rb] = r; m_c = (b == 8'hFF); m_z = (r == 0); end
          else if (ra == 2) begin r = b - 1; m_regs[rb] = r; m_c = (b == 8'h00); m_z = (r == 0); end
        end
        4'd12: begin
          if (ra == 0)      m_regs[rb] = imm;
          else if (ra == 1) m_regs[rb] = m_mem[imm];
          else if (ra == 2) m_mem[imm] = b;
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    logic       seen;
    logic [7:0] p, d;
    rstn    = 1'b1;
    int_sig = 1'b0;
    I_Port  = 8'h3C;
    #1 rstn = 1'b0;
    enter_reset();
    chk("rst_pc", dut.PC.pc_current, 8'h00);
    for (int i = 0; i < 4; i++) chk($sformatf("rst_r%0d", i), dut.regfile_inst.regs[i], 8'h00);
    chk("rst_oport", O_Port, 8'h00);
    chk("rst_z", {7'd0, dut.flag_z}, 8'h00);
    chk("rst_c", {7'd0, dut.flag_c}, 8'h00);

    // LDD R1,[0xF0]
    prog = '{8'hC5, 8'hF0};
    load_prog();
    dut.mem_inst.mem[8'hF0] = 8'hAA;
    rstn = 1'b1;
    tick(10);
    chk("ldd_r1", dut.regfile_inst.regs[1], 8'hAA);
    chk("ldd_mem", dut.mem_inst.mem[8'hF0], 8'hAA);

    // Back-to-back dependencies: ADD then OUT
    enter_reset();
    prog = '{8'hC0, 8'h05, 8'hC1, 8'h03, 8'h21, 8'h60};
    load_prog();
    rstn = 1'b1;
    tick(20);
    chk("haz_oport", O_Port, 8'h08);
    chk("haz_r0", dut.regfile_inst.regs[0], 8'h08);
    chk("haz_r1", dut.regfile_inst.regs[1], 8'h03);
    chk("haz_z", {7'd0, dut.flag_z}, 8'h00);

    // Store then load through the data port
    enter_reset();
    prog = '{8'hC2, 8'h5A, 8'hCA, 8'h80, 8'hC7, 8'h80};
    load_prog();
    rstn = 1'b1;
    tick(20);
    chk("st_mem80", dut.mem_inst.mem[8'h80], 8'h5A);
    chk("st_r3", dut.regfile_inst.regs[3], 8'h5A);

    // Taken JZ flushes the following LDM
    enter_reset();
    prog = '{8'hC0, 8'h00, 8'hC1, 8'h20, 8'h30, 8'h81, 8'hC3, 8'hFF};
    load_prog();
    rstn = 1'b1;
    watch(16, 8'h20, seen);
    chk("br_pc20", {7'd0, seen}, 8'h01);
    chk("br_r3", dut.regfile_inst.regs[3], 8'h00);
    chk("br_z", {7'd0, dut.flag_z}, 8'h01);

`ifdef CPU_INT_EN
    enter_reset();
    dut.mem_inst.mem[8'hF8] = 8'h90;
    rstn = 1'b1;
    tick(5);
    p = dut.PC.pc_current;
    int_sig = 1'b1;
    tick(1);
    int_sig = 1'b0;
    chk("int_vec", dut.PC.pc_current, 8'hF8);
    int_sig = 1'b1;
    tick(1);
    int_sig = 1'b0;
    watch(12, p, seen);
    chk("int_ret", {7'd0, seen}, 8'h01);
    int_sig = 1'b1;
    tick(1);
    int_sig = 1'b0;
    chk("int_again", dut.PC.pc_current, 8'hF8);
`else
    enter_reset();
    rstn = 1'b1;
    tick(5);
    p = dut.PC.pc_current;
    int_sig = 1'b1;
    tick(1);
    int_sig = 1'b0;
    chk("int_ignored", dut.PC.pc_current, p + 8'd1);
`endif

    // Asynchronous reset in the middle of an ADD/OUT stream
    enter_reset();
    prog = '{8'hC0, 8'h05, 8'hC1, 8'h03, 8'h21, 8'h60, 8'h21, 8'h60, 8'h21, 8'h60};
    load_prog();
    rstn = 1'b1;
    tick(14);
    #2 rstn = 1'b0;
    #1;
    chk("mid_pc", dut.PC.pc_current, 8'h00);
    for (int i = 0; i < 4; i++) chk($sformatf("mid_r%0d", i), dut.regfile_inst.regs[i], 8'h00);
    chk("mid_oport", O_Port, 8'h00);

    // Random straight-line programs against the ISA model
    for (int r = 0; r < 3; r++) begin
      enter_reset();
      for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
      for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
      m_z = 1'b0; m_c = 1'b0; m_out = 8'h00;
      I_Port = 8'($urandom);
      gen_random(16);
      load_prog();
      for (int i = 0; i < prog.size(); i++) m_mem[i] = prog[i];
      for (int a = 0; a < 16; a++) begin
        d = 8'($urandom);
        dut.mem_inst.mem[8'hE0 + a[7:0]] = d;
        m_mem[8'hE0 + a[7:0]] = d;
      end
      model_run(prog.size());
      rstn = 1'b1;
      tick(80);
      for (int i = 0; i < 4; i++) chk($sformatf("rnd%0d_r%0d", r, i), dut.regfile_inst.regs[i], m_regs[i]);
      chk($sformatf("rnd%0d_oport", r), O_Port, m_out);
      chk($sformatf("rnd%0d_z", r), {7'd0, dut.flag_z}, {7'd0, m_z});
      chk($sformatf("rnd%0d_c", r), {7'd0, dut.flag_c}, {7'd0, m_c});
      for (int a = 0; a < 16; a++)
        chk($sformatf("rnd%0d_mem%02h", r, 8'hE0 + a), dut.mem_inst.mem[8'hE0 + a[7:0]], m_mem[8'hE0 + a[7:0]]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end
endmodule
